exp_share_arbiter: RTL and testbench
====================================

# exp_share_arbiter

Round-robin arbiter and sequencer that shares one `exponential` accelerator core among `NREQ` requesters. It accepts one operand per valid/ready handshake and drives the core's `start`/`x` inputs. It detects completion on `done` and returns `intpart`/`fracpart` with the requester's ID on one shared response channel. It sits between client blocks and the single `exponential` instance.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: requester ID width, must satisfy 2^IDW >= NREQ.
- `TIMEOUT`, default 255: WAIT-state cycle limit; used only with `EXP_TIMEOUT_EN`. 8-bit.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept; at most one bit high.
- `req_x` in NREQ*16: operands; requester i uses bits [16i+15:16i].
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out IDW: ID of the requester that owns the response.
- `rsp_int` out 2: captured `intpart`.
- `rsp_frac` out 16: captured `fracpart`.
- `rsp_err` out 1: 1 means timeout, with no valid result.
- `core_start` out 1: drives the core's `start`.
- `core_x` out 16: drives the core's `x`.
- `core_done` in 1: from the core's `done`.
- `core_intpart` in 2: from the core.
- `core_fracpart` in 16: from the core.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - Select the first `req_valid` bit at or after the round-robin pointer `ptr`, wrapping modulo NREQ.
  - Drive `req_ready` for that bit only, combinationally from `req_valid` and `ptr`.
  - On the handshake edge: latch the operand into `core_x`, latch the ID, set `ptr` to ID+1 (wrapping NREQ-1 to 0), and go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - Drive `core_start`=1 for exactly this one cycle, then go to WAIT.
  - `core_x` holds from the latch until the next grant.
- **WAIT**
  - A registered copy `done_q` of `core_done` is kept.
  - Completion means a rising edge: `core_done`=1 and `done_q`=0.
  - A level already high on entry to WAIT is not completion.
  - On completion: capture `core_intpart`/`core_fracpart` into the `rsp_*` registers, set `rsp_err`=0, and go to RESP.
- **RESP**
  - Hold `rsp_valid`=1 with `rsp_id`/`rsp_int`/`rsp_frac`/`rsp_err` stable until `rsp_ready`=1.
  - On the handshake edge, go to IDLE.
  - No grant is made in RESP, so at most one operation is in flight.
- Arithmetic:
  - No arithmetic on the data; results pass through bit-exact.
  - `ptr` is IDW bits wide and wraps at NREQ, not at 2^IDW.
- Boundaries:
  - A requester that deasserts `req_valid` before its grant is skipped without side effect.
  - Dropping `req_valid` after its handshake has no effect.
  - `req_x` for non-granted requesters is ignored.
- Reset:
  - `rst` forces IDLE and sets `ptr`=0, `done_q`=0.
  - All outputs reset to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_int`, `rsp_frac`, `rsp_err`, `core_start`, `core_x`.
  - An in-flight operation is dropped with no response. The requester must re-present.
  - Reset in any state takes effect at that edge.

## Timing
- Cycle 0: IDLE handshake (`req_valid` & `req_ready`).
- Cycle 1: `core_start`=1 and `core_x` is valid.
- Cycle 2 onward: WAIT.
- If the `core_done` rising edge is seen at cycle k, then `rsp_valid`=1 from cycle k+1.
- Earliest next grant: the cycle after the response handshake.
- Throughput: one operation per (core latency + 4) cycles minimum.
- `req_ready` is never high outside IDLE.
- `core_start` is never high for more than 1 cycle.

## Configuration
- Macro: `EXP_TIMEOUT_EN`.
- **Defined**
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without completion, go to RESP with `rsp_err`=1, `rsp_int`=0 and `rsp_frac`=0.
  - Completion and timeout on the same cycle: completion wins.
- **Undefined**
  - There is no counter; WAIT persists until completion.
  - `rsp_err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- **Single request:** requester 0 presents `x`=3080 and the core model returns `intpart`=1, `fracpart`=0x2A3C. Expect:
  - `core_start` high exactly one cycle after the handshake, with `core_x`=3080.
  - `rsp_valid`, `rsp_id`=0, `rsp_int`=1, `rsp_frac`=0x2A3C, `rsp_err`=0.
- **Fairness:** all 4 requesters valid together, with `x`=3080, 2481, 100, 0. Expect:
  - Grants in order 0, 1, 2, 3, with matching `rsp_id` and `core_x` values.
  - Requester 0 re-asserts: it is granted next after 3, showing `ptr` wrap.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, while requester 2 is valid. Expect:
  - Response fields stable and `req_ready`=0 throughout.
  - Requester 2 granted the cycle after `rsp_ready`=1.
- **Stale done:** core model holds `done`=1 from the prior operation into the next ISSUE/WAIT, then drops it and re-raises it after 10 cycles. Expect:
  - No response until the re-raise.
  - Capture at that edge.
- **Reset mid-WAIT:** assert `rst` 3 cycles into WAIT for requester 1. Expect:
  - All outputs 0 the next cycle and no response issued.
  - `ptr`=0, so with 1 and 3 valid, requester 1 is granted first.
- **Timeout (`EXP_TIMEOUT_EN`, `TIMEOUT`=16):** `core_done` stuck at 0. Expect:
  - `rsp_valid`=1 with `rsp_err`=1 and zero data, 17 cycles after `core_start`.
  - Without the macro, no response after 1000 cycles.

Source files
------------

// File: rtl/exp_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one exponential core among NREQ requesters.
// Build macro EXP_TIMEOUT_EN adds a WAIT-state timeout reported through rsp_err.
module exp_share_arbiter #(
    parameter int         NREQ    = 4,
    parameter int         IDW     = 2,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_x,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [1:0]           rsp_int,
    output logic [15:0]          rsp_frac,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [15:0]          core_x,
    input  logic                 core_done,
    input  logic [1:0]           core_intpart,
    input  logic [15:0]          core_fracpart
);

    localparam int DW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    if ((1 << IDW) < NREQ || NREQ < 2 || TIMEOUT == 8'd0) begin : g_cfg_err
        $error("exp_share_arbiter: illegal NREQ/IDW/TIMEOUT combination");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [15:0]     r_x;
    logic            r_done_q;
    logic [1:0]      r_int;
    logic [15:0]     r_frac;
    logic            r_err;

    logic            w_any;
    logic [IDW-1:0]  w_gnt_id;
    logic [15:0]     w_gnt_x;
    logic [DW-1:0]   w_dist;
    logic [DW-1:0]   w_best;
    logic            w_cmpl;
    logic            w_tmo;

    // Rotating priority: smallest distance from r_ptr (mod NREQ) wins.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        w_gnt_x  = '0;
        w_best   = DW'(NREQ);
        w_dist   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(r_ptr))
                w_dist = DW'(i - int'(r_ptr));
            else
                w_dist = DW'(i + NREQ - int'(r_ptr));
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_any    = 1'b1;
                w_gnt_id = IDW'(i);
                w_gnt_x  = req_x[16*i +: 16];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = (r_state == S_IDLE) && !rst && w_any && (w_gnt_id == IDW'(i));
    end

    // Only a fresh rising edge of done counts; a level left over from a prior op is ignored.
    assign w_cmpl = core_done & ~r_done_q;

`ifdef EXP_TIMEOUT_EN
    logic [7:0] r_cnt;
    assign w_tmo = (r_state == S_WAIT) && ((r_cnt + 8'd1) == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (r_state == S_ISSUE)
            r_cnt <= '0;
        else if (r_state == S_WAIT)
            r_cnt <= r_cnt + 8'd1;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_cmpl || w_tmo) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_x      <= '0;
            r_done_q <= 1'b0;
            r_int    <= '0;
            r_frac   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= core_done;
            if (r_state == S_IDLE && w_any) begin
                r_x   <= w_gnt_x;
                r_id  <= w_gnt_id;
                r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (r_state == S_WAIT) begin
                if (w_cmpl) begin
                    r_int  <= core_intpart;
                    r_frac <= core_fracpart;
                    r_err  <= 1'b0;
                end else if (w_tmo) begin
                    r_int  <= '0;
                    r_frac <= '0;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign core_start = (r_state == S_ISSUE);
    assign core_x     = r_x;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_int    = r_int;
    assign rsp_frac   = r_frac;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_exp_share_arbiter.sv
// Directed self-checking bench for exp_share_arbiter; the core is modelled by driving done/results directly.
module tb_exp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_x;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [1:0]  rsp_int;
    logic [15:0] rsp_frac;
    logic        rsp_err;
    logic        core_start;
    logic [15:0] core_x;
    logic        core_done;
    logic [1:0]  core_intpart;
    logic [15:0] core_fracpart;

    int n_chk  = 0;
    int n_pass = 0;

    exp_share_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(8'd16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_int       (rsp_int),
        .rsp_frac      (rsp_frac),
        .rsp_err       (rsp_err),
        .core_start    (core_start),
        .core_x        (core_x),
        .core_done     (core_done),
        .core_intpart  (core_intpart),
        .core_fracpart (core_fracpart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rsp_int"},   32'(rsp_int),   32'd0);
        chk({tag, "_rsp_frac"},  32'(rsp_frac),  32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_core_start"},32'(core_start),32'd0);
        chk({tag, "_core_x"},    32'(core_x),    32'd0);
    endtask

    // Waits (bounded) for a grant, checks it, then checks the single-cycle ISSUE. Ends in first WAIT cycle.
    task automatic grant_issue(input int id, input logic [15:0] x);
        int n;
        n = 0;
        #1;
        while (((req_ready & req_valid) == 4'd0) && n < 50) begin
            tick();
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1 << id));
        tick();
        req_valid[id] = 1'b0;
        chk("issue_start", 32'(core_start), 32'd1);
        chk("issue_core_x", 32'(core_x), 32'(x));
        chk("issue_ready_low", 32'(req_ready), 32'd0);
        tick();
        chk("start_one_cycle", 32'(core_start), 32'd0);
    endtask

    // Keeps done low for lat cycles, raises it with results, checks and accepts the response.
    task automatic complete(input int id, input logic [1:0] iv, input logic [15:0] fv, input int lat);
        for (int i = 0; i < lat; i++) begin
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        core_done     = 1'b1;
        core_intpart  = iv;
        core_fracpart = fv;
        rsp_ready     = 1'b1;
        tick();
        core_done     = 1'b0;
        core_intpart  = 2'd0;
        core_fracpart = 16'h0;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id",    32'(rsp_id),    32'(id));
        chk("rsp_int",   32'(rsp_int),   32'(iv));
        chk("rsp_frac",  32'(rsp_frac),  32'(fv));
        chk("rsp_err",   32'(rsp_err),   32'd0);
        tick();
        chk("rsp_accepted", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic logic [15:0] xs [4] = '{16'd3080, 16'd2481, 16'd100, 16'd0};
        rst = 1'b1;
        req_valid = '0;
        req_x = '0;
        rsp_ready = 1'b1;
        core_done = 1'b0;
        core_intpart = '0;
        core_fracpart = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_idle_outputs("reset");

        // Single request
        req_x[15:0] = 16'd3080;
        req_valid = 4'b0001;
        grant_issue(0, 16'd3080);
        complete(0, 2'd1, 16'h2A3C, 5);

        // Fairness, starting from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_x[16*i +: 16] = xs[i];
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            grant_issue(i, xs[i]);
            if (i == 1) req_valid[0] = 1'b1;
            complete(i, 2'(i), 16'h1000 + 16'(i), 3);
        end
        grant_issue(0, 16'd3080);
        complete(0, 2'd1, 16'h2A3C, 2);

        // Backpressure with requester 2 waiting
        req_x[31:16] = 16'h0555;
        req_valid = 4'b0010;
        grant_issue(1, 16'h0555);
        repeat (3) tick();
        core_done = 1'b1;
        core_intpart = 2'd2;
        core_fracpart = 16'hBEEF;
        rsp_ready = 1'b0;
        tick();
        core_done = 1'b0;
        core_intpart = 2'd3;
        core_fracpart = 16'hFFFF;
        req_x[47:32] = 16'h1234;
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id",    32'(rsp_id),    32'd1);
            chk("bp_rsp_int",   32'(rsp_int),   32'd2);
            chk("bp_rsp_frac",  32'(rsp_frac),  32'hBEEF);
            chk("bp_rsp_err",   32'(rsp_err),   32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        core_intpart = 2'd0;
        core_fracpart = 16'h0;
        #1;
        chk("bp_ready_in_resp", 32'(req_ready), 32'd0);
        tick();
        chk("bp_grant_after", 32'(req_ready), 32'd4);
        chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
        grant_issue(2, 16'h1234);
        complete(2, 2'd1, 16'h7777, 1);

        // Stale done carried over from the previous operation
        req_x[63:48] = 16'h0777;
        req_valid = 4'b1000;
        grant_issue(3, 16'h0777);
        repeat (2) tick();
        core_done = 1'b1;
        core_intpart = 2'd1;
        core_fracpart = 16'h0101;
        tick();
        chk("stale_prior_rsp", 32'(rsp_frac), 32'h0101);
        req_x[15:0] = 16'h0AAA;
        req_valid = 4'b0001;
        tick();
        grant_issue(0, 16'h0AAA);
        for (int i = 0; i < 3; i++) begin
            chk("stale_high_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        core_done = 1'b0;
        complete(0, 2'd3, 16'h5A5A, 10);

        // Reset in the middle of WAIT
        req_x[31:16] = 16'h0321;
        req_valid = 4'b0010;
        grant_issue(1, 16'h0321);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("midrst");
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (3) tick();
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        req_x[63:48] = 16'h0999;
        req_valid = 4'b1010;
        #1;
        chk("midrst_ptr0_grant", 32'(req_ready), 32'd2);
        grant_issue(1, 16'h0321);
        complete(1, 2'd0, 16'h0F0F, 2);
        grant_issue(3, 16'h0999);
        complete(3, 2'd2, 16'hA5A5, 4);

        // Core never completes
        req_x[15:0] = 16'h0100;
        req_valid = 4'b0001;
        grant_issue(0, 16'h0100);
`ifdef EXP_TIMEOUT_EN
        for (int c = 2; c < 18; c++) begin
            chk("tmo_not_yet", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_rsp_err",   32'(rsp_err),   32'd1);
        chk("tmo_rsp_int",   32'(rsp_int),   32'd0);
        chk("tmo_rsp_frac",  32'(rsp_frac),  32'd0);
        chk("tmo_rsp_id",    32'(rsp_id),    32'd0);
        tick();
        chk("tmo_accepted",  32'(rsp_valid), 32'd0);
`else
        repeat (1000) tick();
        chk("no_tmo_no_rsp", 32'(rsp_valid), 32'd0);
        chk("no_tmo_err",    32'(rsp_err),   32'd0);
        complete(0, 2'd1, 16'h4321, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
